// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled by rxclk_en, sticky rdy/overrun, per-frame frame_err
//   clk_50m   system clock
//   rst_n     asynchronous active-low reset
//   rxclk_en  one-cycle pulse at 16x baud
//   rx        asynchronous serial line, idle high
//   rdy_clr   one-cycle pulse clearing rdy and overrun
//   data      last good received byte
//   rdy       sticky new-byte flag
//   frame_err stop bit of the most recent frame sampled low
//   overrun   sticky: a byte completed while rdy was still set
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
  state_t               state;
  logic [SYNC_STAGES-1:0] sync;
  logic [3:0]           cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  assign rx_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      sync      <= '1;
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, rx});
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      // later assignments to rdy/overrun below override the clear: a completing byte wins
      if (rxclk_en)
        case (state)
          S_IDLE:
            if (!rx_s) begin
              state <= S_START;
              cnt   <= '0;
            end
          S_START:
            if (cnt == 4'd7) begin
              state <= rx_s ? S_IDLE : S_DATA;
              cnt   <= '0;
              idx   <= '0;
            end else cnt <= cnt + 4'd1;
          S_DATA:
            if (cnt == 4'd15) begin
              shreg[idx] <= rx_s;
              cnt        <= '0;
              if (idx == IW'(DATA_BITS - 1)) state <= S_STOP;
              else idx <= idx + 1'b1;
            end else cnt <= cnt + 4'd1;
          S_STOP:
            if (cnt == 4'd15) begin
              cnt <= '0;
              if (rx_s) begin
                data      <= shreg;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
                // a same-cycle clear acknowledged the old byte, so no overrun
                if (rdy && !rdy_clr) overrun <= 1'b1;
                state     <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_WAIT_IDLE;
              end
            end else cnt <= cnt + 4'd1;
          // a held-low (break) line must return high before a new start is accepted
          S_WAIT_IDLE:
            if (rx_s) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;
  localparam int BIT = 432;
  logic       clk_50m, rst_n, rxclk_en, rx, rdy_clr;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data;
  logic       exp_rdy, exp_fe, exp_ovr;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .rxclk_en(rxclk_en), .rx(rx), .rdy_clr(rdy_clr),
    .data(data), .rdy(rdy), .frame_err(frame_err), .overrun(overrun)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  initial begin
    rxclk_en = 1'b0;
    forever begin
      repeat (26) @(negedge clk_50m);
      rxclk_en = 1'b1;
      @(negedge clk_50m);
      rxclk_en = 1'b0;
    end
  end

  task automatic model_reset();
    exp_data = 8'h00; exp_rdy = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic model_clr();
    exp_rdy = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_ovr  = exp_ovr | exp_rdy;
      exp_rdy  = 1'b1;
      exp_data = b;
      exp_fe   = 1'b0;
    end else exp_fe = 1'b1;
  endtask

  task automatic align_tick();
    do @(posedge clk_50m); while (!rxclk_en);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk_50m);
    end
    #1 rx = stop;
    repeat (BIT) @(posedge clk_50m);
  endtask

  task automatic pulse_clr();
    @(posedge clk_50m);
    #1 rdy_clr = 1'b1;
    @(posedge clk_50m);
    #1 rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL reset_held: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    @(negedge clk_50m) rst_n = 1'b1;
    repeat (100) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL reset_idle: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_basic();
    align_tick();
    send_byte(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL basic_55: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    repeat (1000) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL basic_hold: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    pulse_clr();
    model_clr();
    checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL basic_clr: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_back_to_back();
    align_tick();
    send_byte(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL b2b_overrun: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    pulse_clr();
    model_clr();
    checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL b2b_clr: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_break();
    align_tick();
    send_byte(8'hF0, 1'b0);
    model_frame(8'hF0, 1'b0);
    repeat (3 * BIT) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL break_low: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    rx = 1'b1;
    repeat (11 * BIT) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL break_release: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    send_byte(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL break_recover: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_glitch();
    repeat ($urandom_range(0, 26)) @(posedge clk_50m);
    #1 rx = 1'b0;
    repeat (108) @(posedge clk_50m);
    #1 rx = 1'b1;
    repeat (11 * BIT) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL glitch: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_clr_collision();
    align_tick();
    fork
      send_byte(8'h12, 1'b1);
      begin
        repeat (4130) @(posedge clk_50m);
        #1 rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1 rdy_clr = 1'b0;
      end
    join
    model_clr();
    model_frame(8'h12, 1'b1);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL clr_collision: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hC3;
    align_tick();
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk_50m);
    for (int i = 0; i < 4; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk_50m);
    end
    #1 rx = b[4];
    repeat (BIT / 2) @(posedge clk_50m);
    #1 rst_n = 1'b0;
    model_reset();
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL reset_mid: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    rx = 1'b1;
    repeat (100) @(posedge clk_50m);
    @(negedge clk_50m) rst_n = 1'b1;
    repeat (2 * BIT) @(posedge clk_50m);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL reset_mid_quiet: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
    send_byte(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    #1 checks++;
    if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
      errors++;
      $display("FAIL reset_mid_next: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 300)) @(posedge clk_50m);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        model_clr();
      end
      send_byte(b, 1'b1);
      model_frame(b, 1'b1);
      #1 checks++;
      if ({data, rdy, frame_err, overrun} !== {exp_data, exp_rdy, exp_fe, exp_ovr}) begin
        errors++;
        $display("FAIL random_%0d: got data=%h rdy=%b fe=%b ovr=%b want data=%h rdy=%b fe=%b ovr=%b", n, data, rdy, frame_err, overrun, exp_data, exp_rdy, exp_fe, exp_ovr);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_break();
    test_glitch();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
